// File: rtl/ssp_apb_xfer_ctrl_if.sv
// Bundles the client command/stream signals and the APB2 bus.
// The controller takes the master side and the client/SSP side takes the slave side.
interface ssp_apb_xfer_ctrl_if;
    logic        start;
    logic [4:0]  len;
    logic [15:0] cfg_cr0;
    logic [7:0]  cfg_cpsr;
    logic        cfg_lbm;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [9:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;

    modport master (
        input  start, len, cfg_cr0, cfg_cpsr, cfg_lbm, tx_data, tx_valid, PRDATA,
        output tx_ready, rx_data, rx_valid, busy, done, timeout_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output start, len, cfg_cr0, cfg_cpsr, cfg_lbm, tx_data, tx_valid, PRDATA,
        input  tx_ready, rx_data, rx_valid, busy, done, timeout_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/ssp_apb_xfer_ctrl.sv
// APB2 master that configures a PL022 SSP and moves one burst of 1..16 frames
// through it, reporting completion with done or timeout_err.
module ssp_apb_xfer_ctrl #(
    parameter int MAX_WORDS  = 16,
    parameter int POLL_LIMIT = 255,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    ssp_apb_xfer_ctrl_if.master bus
);
    localparam logic [9:0] ADDR_CR0  = 10'd0;
    localparam logic [9:0] ADDR_CR1  = 10'd1;
    localparam logic [9:0] ADDR_DR   = 10'd2;
    localparam logic [9:0] ADDR_SR   = 10'd3;
    localparam logic [9:0] ADDR_CPSR = 10'd4;
    localparam logic [4:0] MAX_LEN   = 5'(MAX_WORDS);
    localparam logic [4:0] FIFO_LIM  = 5'(FIFO_DEPTH);
    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

    typedef enum logic [4:0] {
        S_IDLE,
        S_CR1_OFF_SETUP, S_CR1_OFF_ACCESS,
        S_CR0_SETUP,     S_CR0_ACCESS,
        S_CPSR_SETUP,    S_CPSR_ACCESS,
        S_CR1_ON_SETUP,  S_CR1_ON_ACCESS,
        S_POLL_SETUP,    S_POLL_ACCESS,
        S_DECIDE,
        S_RD_SETUP,      S_RD_ACCESS,
        S_WR_SETUP,      S_WR_ACCESS,
        S_FIN_SETUP,     S_FIN_ACCESS,
        S_DONE,
        S_ABORT_SETUP,   S_ABORT_ACCESS,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  len_reg, tx_cnt_reg, rx_cnt_reg;
    logic [7:0]  poll_cnt_reg;
    logic [15:0] cr0_reg;
    logic [7:0]  cpsr_reg;
    logic        lbm_reg;
    logic        tnf_reg, rne_reg;
    logic [15:0] tx_word_reg;
    logic [15:0] rx_data_reg;
    logic        rx_valid_reg;

    logic [4:0]  in_flight;
    logic        rx_pending, tx_room;
    logic        tx_ready_c;
    logic        psel_c, penable_c, pwrite_c;
    logic [9:0]  paddr_c;
    logic [15:0] pwdata_c;

    assign in_flight  = tx_cnt_reg - rx_cnt_reg;
    assign rx_pending = (rx_cnt_reg < len_reg) && rne_reg;
    assign tx_room    = (tx_cnt_reg < len_reg) && tnf_reg && (in_flight < FIFO_LIM);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_ready_c = 1'b0;
        case (state_reg)
            S_IDLE:           if (bus.start) state_next = (bus.len == 5'd0) ? S_DONE : S_CR1_OFF_SETUP;
            S_CR1_OFF_SETUP:  state_next = S_CR1_OFF_ACCESS;
            S_CR1_OFF_ACCESS: state_next = S_CR0_SETUP;
            S_CR0_SETUP:      state_next = S_CR0_ACCESS;
            S_CR0_ACCESS:     state_next = S_CPSR_SETUP;
            S_CPSR_SETUP:     state_next = S_CPSR_ACCESS;
            S_CPSR_ACCESS:    state_next = S_CR1_ON_SETUP;
            S_CR1_ON_SETUP:   state_next = S_CR1_ON_ACCESS;
            S_CR1_ON_ACCESS:  state_next = S_POLL_SETUP;
            S_POLL_SETUP:     state_next = S_POLL_ACCESS;
            S_POLL_ACCESS:    state_next = (poll_cnt_reg == POLL_LAST) ? S_ABORT_SETUP : S_DECIDE;
            S_DECIDE: begin
                // Draining RX first keeps the SSP receive FIFO from overflowing.
                if (rx_pending) begin
                    state_next = S_RD_SETUP;
                end else if (tx_room) begin
                    tx_ready_c = 1'b1;
                    state_next = bus.tx_valid ? S_WR_SETUP : S_POLL_SETUP;
                end else if (rx_cnt_reg == len_reg) begin
                    state_next = S_FIN_SETUP;
                end else begin
                    state_next = S_POLL_SETUP;
                end
            end
            S_RD_SETUP:       state_next = S_RD_ACCESS;
            S_RD_ACCESS:      state_next = S_POLL_SETUP;
            S_WR_SETUP:       state_next = S_WR_ACCESS;
            S_WR_ACCESS:      state_next = S_POLL_SETUP;
            S_FIN_SETUP:      state_next = S_FIN_ACCESS;
            S_FIN_ACCESS:     state_next = S_DONE;
            S_DONE:           state_next = S_IDLE;
            S_ABORT_SETUP:    state_next = S_ABORT_ACCESS;
            S_ABORT_ACCESS:   state_next = S_ERR;
            S_ERR:            state_next = S_IDLE;
            default:          state_next = S_IDLE;
        endcase
    end

    // APB outputs decode purely from state, so an asynchronous reset drops PSEL at once.
    always_comb begin
        psel_c    = 1'b0;
        pwrite_c  = 1'b0;
        paddr_c   = 10'd0;
        pwdata_c  = 16'd0;
        case (state_reg)
            S_CR1_OFF_SETUP, S_CR1_OFF_ACCESS, S_FIN_SETUP, S_FIN_ACCESS,
            S_ABORT_SETUP, S_ABORT_ACCESS: begin
                psel_c = 1'b1; pwrite_c = 1'b1; paddr_c = ADDR_CR1;
            end
            S_CR0_SETUP, S_CR0_ACCESS: begin
                psel_c = 1'b1; pwrite_c = 1'b1; paddr_c = ADDR_CR0; pwdata_c = cr0_reg;
            end
            S_CPSR_SETUP, S_CPSR_ACCESS: begin
                psel_c = 1'b1; pwrite_c = 1'b1; paddr_c = ADDR_CPSR; pwdata_c = {8'd0, cpsr_reg};
            end
            S_CR1_ON_SETUP, S_CR1_ON_ACCESS: begin
                psel_c = 1'b1; pwrite_c = 1'b1; paddr_c = ADDR_CR1; pwdata_c = {14'd0, 1'b1, lbm_reg};
            end
            S_POLL_SETUP, S_POLL_ACCESS: begin
                psel_c = 1'b1; paddr_c = ADDR_SR;
            end
            S_RD_SETUP, S_RD_ACCESS: begin
                psel_c = 1'b1; paddr_c = ADDR_DR;
            end
            S_WR_SETUP, S_WR_ACCESS: begin
                psel_c = 1'b1; pwrite_c = 1'b1; paddr_c = ADDR_DR; pwdata_c = tx_word_reg;
            end
            default: ;
        endcase
    end

    assign penable_c = (state_reg == S_CR1_OFF_ACCESS) || (state_reg == S_CR0_ACCESS) ||
                       (state_reg == S_CPSR_ACCESS)    || (state_reg == S_CR1_ON_ACCESS) ||
                       (state_reg == S_POLL_ACCESS)    || (state_reg == S_RD_ACCESS) ||
                       (state_reg == S_WR_ACCESS)      || (state_reg == S_FIN_ACCESS) ||
                       (state_reg == S_ABORT_ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            len_reg      <= 5'd0;
            tx_cnt_reg   <= 5'd0;
            rx_cnt_reg   <= 5'd0;
            poll_cnt_reg <= 8'd0;
            cr0_reg      <= 16'd0;
            cpsr_reg     <= 8'd0;
            lbm_reg      <= 1'b0;
            tnf_reg      <= 1'b0;
            rne_reg      <= 1'b0;
            tx_word_reg  <= 16'd0;
            rx_data_reg  <= 16'd0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        len_reg      <= (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                        cr0_reg      <= bus.cfg_cr0;
                        cpsr_reg     <= bus.cfg_cpsr;
                        lbm_reg      <= bus.cfg_lbm;
                        tx_cnt_reg   <= 5'd0;
                        rx_cnt_reg   <= 5'd0;
                        poll_cnt_reg <= 8'd0;
                        tnf_reg      <= 1'b0;
                        rne_reg      <= 1'b0;
                    end
                end
                S_POLL_ACCESS: begin
                    tnf_reg      <= bus.PRDATA[1];
                    rne_reg      <= bus.PRDATA[2];
                    poll_cnt_reg <= poll_cnt_reg + 8'd1;
                end
                S_DECIDE: begin
                    if (state_next == S_RD_SETUP) begin
                        poll_cnt_reg <= 8'd0;
                    end else if (state_next == S_WR_SETUP) begin
                        poll_cnt_reg <= 8'd0;
                        tx_word_reg  <= bus.tx_data;
                        tx_cnt_reg   <= tx_cnt_reg + 5'd1;
                    end
                end
                S_RD_ACCESS: begin
                    rx_data_reg  <= bus.PRDATA;
                    rx_valid_reg <= 1'b1;
                    rx_cnt_reg   <= rx_cnt_reg + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.PSEL        = psel_c;
    assign bus.PENABLE     = penable_c;
    assign bus.PWRITE      = pwrite_c;
    assign bus.PADDR       = paddr_c;
    assign bus.PWDATA      = pwdata_c;
    assign bus.tx_ready    = tx_ready_c;
    assign bus.rx_data     = rx_data_reg;
    assign bus.rx_valid    = rx_valid_reg;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.timeout_err = (state_reg == S_ERR);
endmodule

// File: tb/tb_ssp_apb_xfer_ctrl.sv
// Directed bench: behavioural PL022 loopback model on the APB side, scenario tasks check
// config order, data path, flow limits, timeout, reset and command edge cases.
module tb_ssp_apb_xfer_ctrl;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    ssp_apb_xfer_ctrl_if bus();

    ssp_apb_xfer_ctrl #(.MAX_WORDS(16), .POLL_LIMIT(255), .FIFO_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // SSP model state and observation logs
    logic [15:0] mq_data[$];
    int          mq_time[$];
    logic [15:0] rq[$];
    int          latency = 3;
    bit          sr_arm = 0;
    bit          sr_dead = 0;
    logic [9:0]  log_addr[$];
    logic        log_wr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    logic [15:0] rx_log[$];
    int          rx_cyc_log[$];
    int dr_wr_cnt = 0, dr_rd_cnt = 0, max_inflight = 0, sr_since_dr = 0;
    int done_cnt = 0, done_cyc = 0, to_cnt = 0, to_cyc = 0, psel_cnt = 0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            mq_data.delete(); mq_time.delete(); rq.delete();
            bus.PRDATA = 16'd0;
            sr_dead = 0;
        end else begin
            if (!sr_arm) sr_dead = 0;
            while (mq_time.size() > 0 && (cyc - mq_time[0]) >= latency) begin
                rq.push_back(mq_data.pop_front());
                void'(mq_time.pop_front());
            end
            if (bus.PSEL) psel_cnt++;
            if (bus.rx_valid) begin rx_log.push_back(bus.rx_data); rx_cyc_log.push_back(cyc); end
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.timeout_err) begin to_cnt++; to_cyc = cyc; end
            if (bus.PSEL && !bus.PENABLE && !bus.PWRITE) begin
                if (bus.PADDR == 10'd3)
                    bus.PRDATA = sr_dead ? 16'd0 : {13'd0, rq.size() > 0, mq_data.size() < 8, 1'b0};
                else if (bus.PADDR == 10'd2)
                    bus.PRDATA = (rq.size() > 0) ? rq[0] : 16'hDEAD;
                else
                    bus.PRDATA = 16'd0;
            end
            if (bus.PSEL && bus.PENABLE) begin
                log_addr.push_back(bus.PADDR); log_wr.push_back(bus.PWRITE);
                log_data.push_back(bus.PWDATA); log_cyc.push_back(cyc);
                if (bus.PADDR == 10'd2 && bus.PWRITE) begin
                    mq_data.push_back(bus.PWDATA); mq_time.push_back(cyc);
                    dr_wr_cnt++; sr_since_dr = 0;
                    if (sr_arm) sr_dead = 1;
                end else if (bus.PADDR == 10'd2) begin
                    if (rq.size() > 0) void'(rq.pop_front());
                    dr_rd_cnt++; sr_since_dr = 0;
                end else if (bus.PADDR == 10'd3) begin
                    sr_since_dr++;
                end
                if (dr_wr_cnt - dr_rd_cnt > max_inflight) max_inflight = dr_wr_cnt - dr_rd_cnt;
            end
        end
    end

    logic [15:0] words[$];
    int          gaps[$];
    int          start_cyc = 0;

    task automatic do_reset();
        bus.start = 1'b0; bus.tx_valid = 1'b0;
        @(posedge PCLK); #1; PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1; PRESETn = 1'b1;
    endtask

    task automatic pulse_start(input logic [4:0] l, input logic [15:0] cr0,
                               input logic [7:0] cpsr, input logic lbm);
        @(posedge PCLK); #1;
        bus.start = 1'b1; bus.len = l; bus.cfg_cr0 = cr0; bus.cfg_cpsr = cpsr; bus.cfg_lbm = lbm;
        start_cyc = cyc;
        @(posedge PCLK); #1;
        bus.start = 1'b0;
    endtask

    task automatic feed_tx();
        for (int i = 0; i < words.size(); i++) begin
            bit acc = 0;
            int guard = 0;
            repeat (gaps[i]) begin @(posedge PCLK); #1; end
            bus.tx_valid = 1'b1; bus.tx_data = words[i];
            while (!acc && guard < 3000 && PRESETn) begin
                @(negedge PCLK); acc = bus.tx_ready;
                @(posedge PCLK); #1; guard++;
            end
            bus.tx_valid = 1'b0;
            if (!acc) break;
        end
    endtask

    task automatic wait_end(input int budget, output bit ok);
        int d0 = done_cnt;
        int t0 = to_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge PCLK); #1;
            if (done_cnt != d0 || to_cnt != t0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.tx_ready, bus.rx_valid,
             bus.rx_data, bus.busy, bus.done, bus.timeout_err} !== 50'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got psel=%b pen=%b busy=%b done=%b paddr=%h, want all 0",
                     bus.PSEL, bus.PENABLE, bus.busy, bus.done, bus.PADDR);
        end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_config();
        int base;
        bit ok;
        logic [9:0]  exp_a[4] = '{10'd1, 10'd0, 10'd4, 10'd1};
        logic [15:0] exp_d[4] = '{16'h0000, 16'h00C7, 16'h0002, 16'h0003};
        do_reset();
        latency = 3; base = log_addr.size();
        words = '{16'h1234}; gaps = '{0};
        pulse_start(5'd1, 16'h00C7, 8'h02, 1'b1);
        fork feed_tx(); wait_end(2000, ok); join
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL config_end: got ended=%0b, want 1", ok); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (base + i >= log_addr.size() || log_addr[base+i] !== exp_a[i] || log_wr[base+i] !== 1'b1 ||
                log_data[base+i] !== exp_d[i] || log_cyc[base+i] !== start_cyc + 2 + 2*i) begin
                tests_failed++;
                $display("FAIL config_access%0d: got addr=%0d wr=%0b data=%h cyc=%0d, want addr=%0d wr=1 data=%h cyc=%0d",
                         i, log_addr[base+i], log_wr[base+i], log_data[base+i], log_cyc[base+i],
                         exp_a[i], exp_d[i], start_cyc + 2 + 2*i);
            end
        end
        $display("[TB] config: 4 config accesses checked, start at cycle %0d", start_cyc);
    endtask

    task automatic test_loopback();
        int base, rb, wb, d0, t0, nwr, last, rd_cyc;
        logic [15:0] wdat;
        bit ok;
        do_reset();
        latency = 3; base = log_addr.size(); rb = rx_log.size(); wb = dr_wr_cnt;
        d0 = done_cnt; t0 = to_cnt;
        words = '{16'hA5A5}; gaps = '{2};
        pulse_start(5'd1, 16'h000F, 8'h04, 1'b1);
        fork feed_tx(); wait_end(2000, ok); join
        nwr = 0; wdat = 16'h0; rd_cyc = -1;
        for (int i = base; i < log_addr.size(); i++) begin
            if (log_addr[i] == 10'd2 && log_wr[i]) begin nwr++; wdat = log_data[i]; end
            if (log_addr[i] == 10'd2 && !log_wr[i]) rd_cyc = log_cyc[i];
        end
        last = log_addr.size() - 1;
        tests_run++;
        if (nwr != 1 || wdat !== 16'hA5A5 || dr_wr_cnt - wb != 1) begin
            tests_failed++; $display("FAIL loop_dr_write: got n=%0d data=%h, want n=1 data=a5a5", nwr, wdat);
        end
        tests_run++;
        if (rx_log.size() - rb != 1 || rx_log[rb] !== 16'hA5A5) begin
            tests_failed++; $display("FAIL loop_rx: got n=%0d data=%h, want n=1 data=a5a5", rx_log.size() - rb, rx_log[rb]);
        end
        tests_run++;
        if (rx_cyc_log[rb] !== rd_cyc + 1) begin
            tests_failed++; $display("FAIL loop_rx_timing: got cyc=%0d, want %0d", rx_cyc_log[rb], rd_cyc + 1);
        end
        tests_run++;
        if (log_addr[last] !== 10'd1 || log_wr[last] !== 1'b1 || log_data[last] !== 16'h0000) begin
            tests_failed++; $display("FAIL loop_cr1_off: got addr=%0d data=%h, want addr=1 data=0000", log_addr[last], log_data[last]);
        end
        tests_run++;
        if (!ok || done_cnt - d0 != 1 || to_cnt != t0 || done_cyc !== log_cyc[last] + 1) begin
            tests_failed++; $display("FAIL loop_done: got done=%0d cyc=%0d, want done=1 cyc=%0d", done_cnt - d0, done_cyc, log_cyc[last] + 1);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL loop_busy_fall: got %b, want 0", bus.busy); end
        $display("[TB] loopback: wrote %h, received %h", wdat, rx_log[rb]);
    endtask

    task automatic test_burst(input logic [4:0] l, input int lat, input bit gapped);
        int rb, wb, d0;
        bit ok;
        do_reset();
        latency = lat; rb = rx_log.size(); wb = dr_wr_cnt; d0 = done_cnt;
        words.delete(); gaps.delete();
        for (int i = 0; i < 16; i++) begin
            words.push_back(16'h3C00 + 16'(i) * 16'h0101);
            gaps.push_back(gapped ? (i % 6) : 0);
        end
        pulse_start(l, 16'h00C7, 8'h02, 1'b1);
        fork feed_tx(); wait_end(5000, ok); join
        tests_run++;
        if (!ok || done_cnt - d0 != 1) begin tests_failed++; $display("FAIL burst_done: got %0d, want 1", done_cnt - d0); end
        tests_run++;
        if (dr_wr_cnt - wb != 16 || rx_log.size() - rb != 16) begin
            tests_failed++; $display("FAIL burst_count: got writes=%0d rx=%0d, want 16/16", dr_wr_cnt - wb, rx_log.size() - rb);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (rb + i >= rx_log.size() || rx_log[rb+i] !== words[i]) begin
                tests_failed++; $display("FAIL burst_rx%0d: got %h, want %h", i, rx_log[rb+i], words[i]);
            end
        end
        tests_run++;
        if (max_inflight > 8) begin tests_failed++; $display("FAIL burst_inflight: got %0d, want <=8", max_inflight); end
        $display("[TB] burst len=%0d lat=%0d: %0d frames, max in flight %0d", l, lat, rx_log.size() - rb, max_inflight);
    endtask

    task automatic test_edge();
        int p0, d0, wb, rb, base, ncr0;
        bit ok;
        do_reset();
        p0 = psel_cnt; d0 = done_cnt;
        pulse_start(5'd0, 16'h00C7, 8'h02, 1'b0);
        wait_end(20, ok);
        tests_run++;
        if (!ok || done_cnt - d0 != 1 || done_cyc !== start_cyc + 1 || psel_cnt != p0) begin
            tests_failed++; $display("FAIL len0: got done_cyc=%0d psel_cycles=%0d, want %0d and 0", done_cyc, psel_cnt - p0, start_cyc + 1);
        end
        latency = 3; wb = dr_wr_cnt; rb = rx_log.size(); base = log_addr.size(); d0 = done_cnt;
        words = '{16'h1111, 16'h2222, 16'h3333}; gaps = '{1, 0, 2};
        pulse_start(5'd3, 16'h0007, 8'h02, 1'b1);
        fork
            feed_tx();
            wait_end(3000, ok);
            begin
                repeat (4) @(posedge PCLK);
                #1; bus.start = 1'b1; bus.len = 5'd7;
                @(posedge PCLK); #1; bus.start = 1'b0;
            end
        join
        ncr0 = 0;
        for (int i = base; i < log_addr.size(); i++) if (log_addr[i] == 10'd0 && log_wr[i]) ncr0++;
        tests_run++;
        if (!ok || dr_wr_cnt - wb != 3 || rx_log.size() - rb != 3 || ncr0 != 1 || done_cnt - d0 != 1) begin
            tests_failed++; $display("FAIL start_busy: got writes=%0d rx=%0d cr0=%0d done=%0d, want 3/3/1/1",
                                     dr_wr_cnt - wb, rx_log.size() - rb, ncr0, done_cnt - d0);
        end
        $display("[TB] edge: len=0 and start-while-busy checked");
    endtask

    task automatic test_timeout();
        int d0, t0, last;
        bit ok;
        do_reset();
        latency = 3; sr_arm = 1; d0 = done_cnt; t0 = to_cnt;
        words = '{16'h0F0F}; gaps = '{0};
        pulse_start(5'd1, 16'h00C7, 8'h02, 1'b1);
        fork feed_tx(); wait_end(3000, ok); join
        sr_arm = 0;
        last = log_addr.size() - 1;
        tests_run++;
        if (!ok || to_cnt - t0 != 1 || done_cnt != d0) begin
            tests_failed++; $display("FAIL timeout_pulse: got timeout=%0d done=%0d, want 1/0", to_cnt - t0, done_cnt - d0);
        end
        tests_run++;
        if (sr_since_dr != 255) begin tests_failed++; $display("FAIL timeout_polls: got %0d, want 255", sr_since_dr); end
        tests_run++;
        if (log_addr[last] !== 10'd1 || log_data[last] !== 16'h0000 || to_cyc !== log_cyc[last] + 1) begin
            tests_failed++; $display("FAIL timeout_cr1_off: got addr=%0d data=%h to_cyc=%0d, want 1/0000/%0d",
                                     log_addr[last], log_data[last], to_cyc, log_cyc[last] + 1);
        end
        $display("[TB] timeout: %0d SR polls after last DR write", sr_since_dr);
    endtask

    task automatic test_reset_mid();
        int wb, base;
        bit hit, ok;
        logic [15:0] exp_d[4] = '{16'h0000, 16'h0047, 16'h0008, 16'h0002};
        logic [9:0]  exp_a[4] = '{10'd1, 10'd0, 10'd4, 10'd1};
        do_reset();
        latency = 30; wb = dr_wr_cnt; hit = 0;
        words = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006, 16'hB007};
        gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
        pulse_start(5'd8, 16'h00C7, 8'h02, 1'b1);
        fork
            feed_tx();
            for (int i = 0; i < 1000; i++) begin
                @(posedge PCLK); #1;
                if (bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PADDR == 10'd2 && dr_wr_cnt - wb == 4) begin
                    PRESETn = 1'b0; #1;
                    hit = 1;
                    tests_run++;
                    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 ||
                        {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.tx_ready, bus.rx_valid, bus.rx_data,
                         bus.busy, bus.done, bus.timeout_err} !== 48'd0) begin
                        tests_failed++; $display("FAIL reset_mid_outputs: got psel=%b pen=%b busy=%b, want 0",
                                                 bus.PSEL, bus.PENABLE, bus.busy);
                    end
                    break;
                end
            end
        join
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL reset_mid_reach: got word5 access=0, want 1"); end
        @(posedge PCLK); #1; PRESETn = 1'b1;
        latency = 3; base = log_addr.size();
        words = '{16'hC0DE}; gaps = '{0};
        pulse_start(5'd1, 16'h0047, 8'h08, 1'b0);
        fork feed_tx(); wait_end(2000, ok); join
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (!ok || base + i >= log_addr.size() || log_addr[base+i] !== exp_a[i] || log_data[base+i] !== exp_d[i]) begin
                tests_failed++; $display("FAIL reset_mid_reconfig%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                                         i, log_addr[base+i], log_data[base+i], exp_a[i], exp_d[i]);
            end
        end
        $display("[TB] reset mid-burst: reconfig after release checked");
    endtask

    initial begin
        bus.start = 1'b0; bus.len = 5'd0; bus.cfg_cr0 = 16'd0; bus.cfg_cpsr = 8'd0; bus.cfg_lbm = 1'b0;
        bus.tx_data = 16'd0; bus.tx_valid = 1'b0;
        test_reset();
        test_config();
        test_loopback();
        test_burst(5'd16, 20, 1'b1);
        test_burst(5'd20, 2, 1'b0);
        test_edge();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
